// File: rtl/lsu_mem_if_if.sv
// Core-side and memory-side signal bundle of the load/store initiator.
// Ports: slave = LSU view, master = core plus data-memory view.
interface lsu_mem_if_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 8
);
    logic             req_i;
    logic             we_i;
    logic [2:0]       funct3_i;
    logic [31:0]      addr_i;
    logic [DW-1:0]    wdata_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [DW-1:0]    rdata_o;
    logic             mem_cs_o;
    logic             mem_we_o;
    logic [3:0]       mem_mask_o;
    logic [ADDRW-1:0] mem_addr_o;
    logic [DW-1:0]    mem_wdata_o;
    logic [DW-1:0]    mem_rdata_i;

    modport slave (
        input  req_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
        output busy_o, done_o, err_o, rdata_o,
        output mem_cs_o, mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
        input  busy_o, done_o, err_o, rdata_o,
        input  mem_cs_o, mem_we_o, mem_mask_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store initiator: byte address + funct3 -> word beats with lane masks.
// Ports: clk_i, rst_i (async, active-low), bus (lsu_mem_if_if.slave).
// Macro LSU_MISALIGN_SPLIT_EN enables two-beat misaligned H/W accesses.
module lsu_mem_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    lsu_mem_if_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC1,
        S_ACC2,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [ADDRW+1:0] addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             err_q, err_d;

    function automatic logic needs_split(input logic [2:0] f3,
                                         input logic [1:0] off);
        needs_split = (f3[1:0] == 2'b01 && off == 2'd3) ||
                      (f3[1:0] == 2'b10 && off != 2'd0);
    endfunction

    // Select bytes from the {beat2, beat1} pair and extend per funct3.
    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [63:0] pair);
        logic [31:0] w;
        w = 32'(pair >> {off, 3'b000});
        case (f3)
            3'b000:  load_ext = {{24{w[7]}}, w[7:0]};
            3'b001:  load_ext = {{16{w[15]}}, w[15:0]};
            3'b100:  load_ext = {24'h0, w[7:0]};
            3'b101:  load_ext = {16'h0, w[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    // Request decode, seen only while idle.
    logic size_ok;
    logic bad_in;

    always_comb begin
        if (bus.we_i)
            size_ok = (bus.funct3_i inside {3'b000, 3'b001, 3'b010});
        else
            size_ok = (bus.funct3_i inside {3'b000, 3'b001, 3'b010,
                                            3'b100, 3'b101});
`ifdef LSU_MISALIGN_SPLIT_EN
        bad_in = !size_ok;
`else
        bad_in = !size_ok || needs_split(bus.funct3_i, bus.addr_i[1:0]);
`endif
    end

    // Lane data and masks from the latched request.
    logic [1:0]  off_l;
    logic        split_l;
    logic [31:0] rep;
    logic [3:0]  base;
    logic [31:0] lane;
    logic [3:0]  mask1;
    logic [ADDRW-1:0] word1;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0]  m8;
    logic [3:0]  mask2;
    logic [ADDRW-1:0] word2;
`endif

    always_comb begin
        off_l   = addr_q[1:0];
        split_l = needs_split(f3_q, off_l);
        word1   = addr_q[ADDRW+1:2];
        case (f3_q[1:0])
            2'b00: begin
                rep  = {4{wdata_q[7:0]}};
                base = 4'b0001;
            end
            2'b01: begin
                rep  = {2{wdata_q[15:0]}};
                base = 4'b0011;
            end
            default: begin
                rep  = wdata_q;
                base = 4'b1111;
            end
        endcase
        // Rotate left by whole bytes so each byte lands in its lane.
        lane = 32'(({rep, rep} << {off_l, 3'b000}) >> 32);
`ifdef LSU_MISALIGN_SPLIT_EN
        m8    = {4'b0000, base} << off_l;
        mask1 = m8[3:0];
        mask2 = m8[7:4];
        word2 = word1 + ADDRW'(1);
`else
        mask1 = base << off_l;
`endif
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_i)
                    state_d = bad_in ? S_DONE : S_ACC1;
            end
            S_ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d = split_l ? S_ACC2 : S_DONE;
`else
                state_d = S_DONE;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_ACC2: state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch and load-result capture.
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] beat1_q, beat1_d;
`endif

    always_comb begin
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        beat1_d = beat1_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    f3_d    = bus.funct3_i;
                    addr_d  = bus.addr_i[ADDRW+1:0];
                    wdata_d = bus.wdata_i;
                    err_d   = bad_in;
                end
            end
            S_ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                beat1_d = bus.mem_rdata_i;
                if (!we_q && !split_l)
                    rdata_d = load_ext(f3_q, off_l, {32'h0, bus.mem_rdata_i});
`else
                if (!we_q)
                    rdata_d = load_ext(f3_q, off_l, {32'h0, bus.mem_rdata_i});
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_ACC2: begin
                if (!we_q)
                    rdata_d = load_ext(f3_q, off_l, {bus.mem_rdata_i, beat1_q});
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            beat1_q <= '0;
`endif
        end else begin
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            beat1_q <= beat1_d;
`endif
        end
    end

    // Outputs.
    always_comb begin
        bus.busy_o      = (state_q != S_IDLE);
        bus.done_o      = (state_q == S_DONE);
        bus.err_o       = (state_q == S_DONE) && err_q;
        bus.rdata_o     = rdata_q;
        bus.mem_cs_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_mask_o  = 4'b0000;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        case (state_q)
            S_ACC1: begin
                bus.mem_cs_o    = 1'b1;
                bus.mem_we_o    = we_q;
                bus.mem_addr_o  = word1;
                bus.mem_mask_o  = we_q ? mask1 : 4'b0000;
                bus.mem_wdata_o = we_q ? lane : '0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_ACC2: begin
                bus.mem_cs_o    = 1'b1;
                bus.mem_we_o    = we_q;
                bus.mem_addr_o  = word2;
                bus.mem_mask_o  = we_q ? mask2 : 4'b0000;
                bus.mem_wdata_o = we_q ? lane : '0;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if with a 256-word byte-masked memory model.
// Beats are logged at each clock edge while mem_cs_o is high.
module tb_lsu_mem_if;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lsu_mem_if_if #(.DW(32), .ADDRW(8)) bus ();

    lsu_mem_if #(.DW(32), .ADDRW(8)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:255];
    logic [7:0]  b_addr [$];
    logic [3:0]  b_mask [$];
    logic [31:0] b_wd   [$];

    assign bus.mem_rdata_i = mem[bus.mem_addr_o];

    always @(posedge clk) begin
        if (bus.mem_cs_o) begin
            b_addr.push_back(bus.mem_addr_o);
            b_mask.push_back(bus.mem_mask_o);
            b_wd.push_back(bus.mem_wdata_o);
            if (bus.mem_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (bus.mem_mask_o[i])
                        mem[bus.mem_addr_o][8*i +: 8] <= bus.mem_wdata_o[8*i +: 8];
            end
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          lat;
    logic        err;
    logic [31:0] rd;

    task automatic clear_log();
        b_addr.delete();
        b_mask.delete();
        b_wd.delete();
    endtask

    // Issue one request; lat counts cycles after the accepting edge.
    task automatic access(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        clear_log();
        @(negedge clk);
        bus.req_i    = 1'b1;
        bus.we_i     = we;
        bus.funct3_i = f3;
        bus.addr_i   = a;
        bus.wdata_i  = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        lat = 1;
        while (!bus.done_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done_o)
            check("done_timeout", 32'(bus.done_o), 32'd1);
        err = bus.err_o;
        rd  = bus.rdata_o;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;
        bus.req_i    = 1'b0;
        bus.we_i     = 1'b0;
        bus.funct3_i = 3'b000;
        bus.addr_i   = 32'h0;
        bus.wdata_i  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(bus.busy_o), 32'd0);
        check("rst_done",  32'(bus.done_o), 32'd0);
        check("rst_err",   32'(bus.err_o), 32'd0);
        check("rst_cs",    32'(bus.mem_cs_o), 32'd0);
        check("rst_we",    32'(bus.mem_we_o), 32'd0);
        check("rst_mask",  32'(bus.mem_mask_o), 32'd0);
        check("rst_addr",  32'(bus.mem_addr_o), 32'd0);
        check("rst_wdata", bus.mem_wdata_o, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the first beat of a store.
        clear_log();
        @(negedge clk);
        bus.req_i    = 1'b1;
        bus.we_i     = 1'b1;
        bus.funct3_i = 3'b010;
        bus.addr_i   = 32'h40;
        bus.wdata_i  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        check("midrst_cs_before", 32'(bus.mem_cs_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_cs", 32'(bus.mem_cs_o), 32'd0);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy_after", 32'(bus.busy_o), 32'd0);
        check("midrst_mem", mem[16], 32'h0);
        check("midrst_beats", 32'(b_addr.size()), 32'd0);

        // Aligned SW.
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_err", 32'(err), 32'd0);
        check("sw_nbeats", 32'(b_addr.size()), 32'd1);
        if (b_addr.size() == 1) begin
            check("sw_addr", 32'(b_addr[0]), 32'd4);
            check("sw_mask", 32'(b_mask[0]), 32'hF);
            check("sw_wdata", b_wd[0], 32'hDEADBEEF);
        end
        check("sw_mem", mem[4], 32'hDEADBEEF);
        check("sw_rd_keep", rd, 32'h0);

        // SB at lane 3.
        access(1'b1, 3'b000, 32'h23, 32'h000000A5);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_nbeats", 32'(b_addr.size()), 32'd1);
        if (b_addr.size() == 1) begin
            check("sb_addr", 32'(b_addr[0]), 32'd8);
            check("sb_mask", 32'(b_mask[0]), 32'h8);
            check("sb_wdata", b_wd[0], 32'hA5A5A5A5);
        end
        check("sb_mem", mem[8], 32'hA5000000);

        access(1'b0, 3'b000, 32'h23, 32'h0);
        check("lb_rd", rd, 32'hFFFFFFA5);
        check("lb_lat", 32'(lat), 32'd2);
        if (b_mask.size() == 1)
            check("lb_mask", 32'(b_mask[0]), 32'h0);
        access(1'b0, 3'b100, 32'h23, 32'h0);
        check("lbu_rd", rd, 32'h000000A5);

        // Loads from the preloaded words.
        access(1'b0, 3'b001, 32'h01, 32'h0);
        check("lh1_rd", rd, 32'h00003322);
        check("lh1_lat", 32'(lat), 32'd2);
        check("lh1_err", 32'(err), 32'd0);
        access(1'b0, 3'b001, 32'h02, 32'h0);
        check("lh2_rd", rd, 32'h00004433);
        access(1'b0, 3'b010, 32'hFFFF0010, 32'h0);
        check("lw_hiaddr_rd", rd, 32'hDEADBEEF);
        access(1'b0, 3'b001, 32'h06, 32'h0);
        check("lh6_rd", rd, 32'hFFFF8877);
        access(1'b0, 3'b101, 32'h06, 32'h0);
        check("lhu6_rd", rd, 32'h00008877);
        access(1'b0, 3'b000, 32'h00, 32'h0);
        check("lb0_rd", rd, 32'h00000011);

        // Misaligned LH crossing words.
        access(1'b0, 3'b001, 32'h03, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("lh3_rd", rd, 32'h00005544);
        check("lh3_lat", 32'(lat), 32'd3);
        check("lh3_err", 32'(err), 32'd0);
        check("lh3_nbeats", 32'(b_addr.size()), 32'd2);
        if (b_addr.size() == 2) begin
            check("lh3_addr1", 32'(b_addr[0]), 32'd0);
            check("lh3_addr2", 32'(b_addr[1]), 32'd1);
        end
`else
        check("lh3_err", 32'(err), 32'd1);
        check("lh3_lat", 32'(lat), 32'd1);
        check("lh3_rd_keep", rd, 32'h00000011);
        check("lh3_nbeats", 32'(b_addr.size()), 32'd0);
`endif

        // Aligned SH in the upper half.
        access(1'b1, 3'b001, 32'h0A, 32'h0000BEEF);
        check("sh_nbeats", 32'(b_addr.size()), 32'd1);
        if (b_addr.size() == 1) begin
            check("sh_addr", 32'(b_addr[0]), 32'd2);
            check("sh_mask", 32'(b_mask[0]), 32'hC);
            check("sh_wdata", b_wd[0], 32'hBEEFBEEF);
        end
        check("sh_mem", mem[2], 32'hBEEF0000);

        // Misaligned SW at the top of memory.
        access(1'b1, 3'b010, 32'h3FE, 32'h11223344);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("swx_lat", 32'(lat), 32'd3);
        check("swx_err", 32'(err), 32'd0);
        check("swx_nbeats", 32'(b_addr.size()), 32'd2);
        if (b_addr.size() == 2) begin
            check("swx_addr1", 32'(b_addr[0]), 32'd255);
            check("swx_mask1", 32'(b_mask[0]), 32'hC);
            check("swx_wdata1", b_wd[0], 32'h33441122);
            check("swx_addr2", 32'(b_addr[1]), 32'd0);
            check("swx_mask2", 32'(b_mask[1]), 32'h3);
        end
        check("swx_mem255", mem[255], 32'h33440000);
        check("swx_mem0", mem[0], 32'h44331122);
`else
        check("swx_err", 32'(err), 32'd1);
        check("swx_lat", 32'(lat), 32'd1);
        check("swx_nbeats", 32'(b_addr.size()), 32'd0);
        check("swx_mem255", mem[255], 32'h0);
`endif

        // Illegal funct3 codes.
        access(1'b0, 3'b011, 32'h00, 32'h0);
        check("ld011_err", 32'(err), 32'd1);
        check("ld011_lat", 32'(lat), 32'd1);
        check("ld011_nbeats", 32'(b_addr.size()), 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
        check("ld011_rd_keep", rd, 32'h00005544);
`else
        check("ld011_rd_keep", rd, 32'h00000011);
`endif
        access(1'b1, 3'b100, 32'h30, 32'hFFFFFFFF);
        check("st100_err", 32'(err), 32'd1);
        check("st100_nbeats", 32'(b_addr.size()), 32'd0);
        check("st100_mem", mem[12], 32'h0);

        // A request held high while busy must not start a second access.
        clear_log();
        @(negedge clk);
        bus.req_i    = 1'b1;
        bus.we_i     = 1'b1;
        bus.funct3_i = 3'b010;
        bus.addr_i   = 32'h50;
        bus.wdata_i  = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        bus.addr_i  = 32'h60;
        bus.wdata_i = 32'h0BADBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req_i = 1'b0;
        check("busyreq_done", 32'(bus.done_o), 32'd1);
        check("busyreq_err", 32'(bus.err_o), 32'd0);
        @(negedge clk);
        check("busyreq_idle", 32'(bus.busy_o), 32'd0);
        check("busyreq_nbeats", 32'(b_addr.size()), 32'd1);
        check("busyreq_mem1", mem[20], 32'hCAFEF00D);
        check("busyreq_mem2", mem[24], 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store initiator between the pipeline's memory stage and the word-addressed, byte-masked data memory.
- Converts a byte address plus RV32 funct3 into word address, lane mask and lane-aligned write data.
- On loads, extracts and sign- or zero-extends the selected bytes.
- Sequences one or two memory beats under a small FSM with a req/done handshake to the core.

Parameters:
DW 32 data width; only 32 is supported
ADDRW 8 memory word-address width (1 KB memory)

Ports:
clk_i input 1 clock
rst_i input 1 asynchronous reset, active-low
req_i input 1 access request; sampled only in IDLE
we_i input 1 1 = store, 0 = load
funct3_i input 3 RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i input 32 byte address
wdata_i input DW store data, right-justified
busy_o output 1 FSM not in IDLE
done_o output 1 one-cycle completion pulse
err_o output 1 valid with done_o: illegal funct3, or misaligned access when splitting is disabled
rdata_o output DW extended load result; held until the next done_o
mem_cs_o output 1 memory chip select
mem_we_o output 1 memory write enable
mem_mask_o output 4 byte-lane write mask
mem_addr_o output ADDRW word address
mem_wdata_o output DW lane-aligned write data
mem_rdata_i input DW combinational read data for mem_addr_o

Behaviour:
- Reset (rst_i low, asynchronous):
  - FSM goes to IDLE.
  - busy_o, done_o, err_o, mem_cs_o, mem_we_o, mem_mask_o all 0.
  - mem_addr_o, mem_wdata_o, rdata_o 0.
  - Reset mid-access aborts the access; no further memory beat is issued.
- States:
  - IDLE: req_i=1 latches we, funct3, addr, wdata. Goes to ACC1, or to DONE with error flag set if the access is illegal.
  - ACC1: first beat. mem_cs_o=1, mem_we_o=we, word address = addr[ADDRW+1:2]. Load data captured at the clock edge. Goes to ACC2 if a split is needed, else DONE.
  - ACC2: second beat at word address +1, wrapping modulo 2^ADDRW. Goes to DONE.
  - DONE: done_o=1, err_o valid, rdata_o updated (loads only). Always goes to IDLE.
- busy_o = (state != IDLE). req_i is ignored while busy_o=1.
- Latency, with req_i accepted at edge N:
  - Aligned access: done_o high in cycle N+2.
  - Split access: done_o high in cycle N+3.
  - Back-to-back requests: next acceptance earliest in the cycle after done_o.
- Outside ACC1/ACC2: mem_cs_o=0, mem_we_o=0, mem_mask_o=0.
- Loads drive mem_mask_o=0; the mask is used for writes only.
- Lane logic, with off = addr[1:0]:
  - Store data: mem_wdata_o = wdata replicated per size (B: 4×byte, H: 2×half, W: word), then rotated left by 8*off. The same value is used on both beats.
  - Byte mask: 0001<<off.
  - Halfword mask: 0011<<off, truncated to 4 bits.
  - Word mask: 1111<<off, truncated to 4 bits.
  - Second-beat mask: the bits shifted out of the first-beat mask (1111>>(4-off) for word, 0001 for halfword at off=3).
- Split needed: H with off=3, or W with off!=0.
- Load assembly:
  - Form {beat2_data, beat1_data}; beat2_data is 0 when there is no split.
  - Shift right by 8*off and take the low 32 bits.
  - Sign-extend for B/H, zero-extend for BU/HU, pass W through.
- Illegal cases (no memory beat, err_o=1 at DONE, rdata_o unchanged):
  - Load funct3 011, 110 or 111.
  - Store funct3 other than 000, 001, 010.
- Address bits [31:ADDRW+2] are ignored.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned H/W accesses are split into two beats as above.
- Undefined:
  - Any access needing a split is illegal: no memory beat, done_o with err_o=1, rdata_o unchanged.
  - ACC2 is not implemented.

Test Plan:
- Reset mid-ACC1 on a store: assert rst_i=0 -> mem_cs_o drops to 0 immediately. After release, busy_o=0 and the memory contents are unchanged.
- Aligned SW addr 0x10, data 0xDEADBEEF -> ACC1: mem_addr_o=4, mask 1111, wdata 0xDEADBEEF. done_o at N+2, err_o=0.
- SB addr 0x23, data 0x000000A5 -> mem_addr_o=8, mask 1000, wdata 0xA5A5A5A5. Then LB 0x23 gives rdata_o=0xFFFFFFA5; LBU 0x23 gives 0x000000A5.
- Memory word 0 = 0x44332211, word 1 = 0x88776655. LH addr 0x01 -> rdata_o=0x00003322, no split, done at N+2. LH addr 0x03 with split enabled -> rdata_o=0x00005544, beats at word 0 then word 1, done at N+3.
- Split enabled, SW addr 0x3FE (ADDRW=8), data 0x11223344:
  - Beat 1: word 255, mask 1100, wdata 0x33441122.
  - Beat 2: word 0 (wrap), mask 0011.
  - Split disabled: same request gives done_o=1, err_o=1, no mem_cs_o pulse.
- Load funct3=011 -> done_o=1, err_o=1 at N+1, mem_cs_o never asserted. A req_i pulse during busy_o=1 is ignored.
